// File: rtl/stream_mux_rr_if.sv
// Purpose: handshake bundle between N_CH input streams and one registered output stream.
// Latency: none, wiring only.
// Backpressure: carries in_ready per channel and out_ready from downstream.
// Ports: in_valid/in_data/in_ready per channel, mode/sel grant control,
//        out_valid/out_data/out_ch/out_ready on the merged output.
interface stream_mux_rr_if #(
    parameter int N_CH = 8,
    parameter int W    = 8,
    parameter int SW   = 3
);
    logic [N_CH-1:0]   in_valid;
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_ready;
    logic              mode;
    logic [SW-1:0]     sel;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_ch;
    logic              out_ready;

    // Traffic source / sink side (bench or surrounding logic).
    modport master (
        output in_valid, in_data, mode, sel, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    // Multiplexer side.
    modport slave (
        input  in_valid, in_data, mode, sel, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// Purpose: N_CH:1 stream multiplexer, fixed-select or round-robin grant, one output register.
// Latency: 1 cycle from input transfer to out_valid; 1 transfer/cycle sustained.
// Backpressure: output register reloads only when empty or being drained; otherwise in_ready is all zero.
// Ports: clk, rst_n (async active-low), bus (stream_mux_rr_if.slave) carrying the
//        per-channel inputs, mode/sel, and the registered out_valid/out_data/out_ch.
module stream_mux_rr #(
    parameter int N_CH = 8,
    parameter int W    = 8,
    parameter int SW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    stream_mux_rr_if.slave   bus
);

    logic [SW-1:0]   last;
    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic [SW-1:0]   out_ch_q;

    logic            load_en;
    logic            grant_vld;
    logic [SW-1:0]   grant_ch;
    logic [W-1:0]    grant_dat;
    logic [N_CH-1:0] ready_vec;

    // Register may take a new word when it is empty or its word leaves this cycle.
    assign load_en = !out_valid_q || bus.out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        if (!bus.mode) begin
            // Fixed select; an out-of-range sel simply matches no channel.
            for (int i = 0; i < N_CH; i++) begin
                if (int'(bus.sel) == i && bus.in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_ch  = SW'(i);
                end
            end
        end else begin
            // Round-robin: first look above last, then wrap to 0..last.
            for (int i = 0; i < N_CH; i++) begin
                if (!grant_vld && i > int'(last) && bus.in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_ch  = SW'(i);
                end
            end
            for (int i = 0; i < N_CH; i++) begin
                if (!grant_vld && i <= int'(last) && bus.in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_ch  = SW'(i);
                end
            end
        end
    end

    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_ch == SW'(i)) begin
                grant_dat = bus.in_data[i*W +: W];
            end
        end
    end

    // rst_n gates in_ready so nothing is accepted while reset is held.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < N_CH; i++) begin
            ready_vec[i] = rst_n && load_en && grant_vld && (grant_ch == SW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last        <= SW'(N_CH - 1);
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid_q <= 1'b1;
                out_data_q  <= grant_dat;
                out_ch_q    <= grant_ch;
                last        <= grant_ch;
            end else begin
                // Drained with nothing to replace it: data/ch keep their old values.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter N_CH, default 8, number of input channels, legal range 2..16.
REQ-002 The block SHALL have parameter W, default 8, data width per channel, legal range 1..64.
REQ-003 The block SHALL have parameter SW, default 3, select/channel-index width, equal to ceil(log2(N_CH)).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, N_CH, per-channel data-valid.
REQ-007 The block SHALL have port in_data, input, N_CH*W, channel i at bits [i*W+W-1 : i*W].
REQ-008 The block SHALL have port in_ready, output, N_CH, per-channel accept, one-hot or zero.
REQ-009 The block SHALL have port mode, input, 1: 0 = fixed select, 1 = round-robin.
REQ-010 The block SHALL have port sel, input, SW, the channel index used when mode = 0.
REQ-011 The block SHALL have port out_valid, output, 1, output register holds data.
REQ-012 The block SHALL have port out_data, output, W, registered data of the granted channel.
REQ-013 The block SHALL have port out_ch, output, SW, index of the channel that supplied out_data.
REQ-014 The block SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-015 The block SHALL define load_en = !out_valid || out_ready, evaluated combinationally each cycle.
REQ-016 In mode 0, the block SHALL grant channel sel when sel < N_CH and in_valid[sel] = 1; otherwise there is no grant.
REQ-017 In mode 1, the block SHALL grant the first channel with in_valid set, searching upward from (last+1) mod N_CH and wrapping, where last is the rr pointer.
REQ-018 The block SHALL drive in_ready[i] = 1 only when load_en = 1 and channel i is granted; all other in_ready bits SHALL be 0.
REQ-019 An input transfer SHALL occur on a cycle with in_valid[i] && in_ready[i] set; on the next edge the block SHALL load out_data = data of channel i, out_ch = i, and out_valid = 1.
REQ-020 When load_en = 1 and there is no grant, the block SHALL set out_valid to 0 on the next edge and leave out_data and out_ch unchanged.
REQ-021 When load_en = 0, the block SHALL hold out_valid, out_data and out_ch unchanged, and all in_ready bits SHALL be 0.
REQ-022 Latency from input transfer to out_valid SHALL be exactly 1 cycle; sustained throughput SHALL be 1 transfer per cycle when out_ready is held at 1.
REQ-023 The rr pointer last SHALL update to i on every input transfer from channel i, in either mode; it SHALL not change otherwise.
REQ-024 A change of mode or sel SHALL affect only the grant in the same cycle and SHALL never alter a value already held in the output register.
REQ-025 Under a simultaneous output transfer (out_valid && out_ready) and input transfer, the block SHALL replace the held word with the new one without a bubble.
REQ-026 Round-robin SHALL be starvation-free: with all N_CH channels valid continuously, each channel SHALL be granted exactly once per N_CH consecutive transfers.

Reset
REQ-027 While rst_n = 0, the block SHALL force out_valid = 0, out_data = 0, out_ch = 0 and last = N_CH-1, so the first round-robin grant goes to channel 0.
REQ-028 While rst_n = 0, the block SHALL force in_ready = 0 regardless of the other inputs.
REQ-029 An assertion of rst_n mid-transfer SHALL discard the held word; no input transfer SHALL be recorded in that cycle.
REQ-030 Release of rst_n SHALL take effect on the first rising clk edge after deassertion.

Verification
REQ-031 The bench SHALL cover mode 0 with sel = 5, in_valid = 8'hFF, channel 5 data = 8'hA5, out_ready = 1 -> in_ready = 8'h20; next cycle out_valid = 1, out_data = 8'hA5, out_ch = 5.
REQ-032 The bench SHALL cover mode 1 after reset with in_valid = 8'hFF held and out_ready = 1 -> grants 0,1,...,7,0 on successive cycles, with out_ch following one cycle later.
REQ-033 The bench SHALL cover mode 1 with in_valid = 8'b1000_0010 and last = 1 -> grant 7, then grant 1 (wrap-around).
REQ-034 The bench SHALL cover out_valid = 1 with out_ready = 0 for 3 cycles while inputs change -> in_ready = 0, out_data and out_ch stable; on out_ready = 1, the next word loads with no bubble.
REQ-035 The bench SHALL cover mode 0 with sel = 3 and in_valid[3] = 0, and separately N_CH = 6 with sel = 7 -> no grant, in_ready = 0, and out_valid falls to 0 after any output transfer.
REQ-036 The bench SHALL cover rst_n pulsed low mid-stream with out_valid = 1 -> out_valid = 0 immediately (asynchronous); the next round-robin grant after release is channel 0.
